// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// pc_fetch_ctrl_if : instruction-memory and decode handshakes of the fetch unit
// Rev 1.0
// ============================================================================
interface pc_fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// pc_fetch_ctrl : PC owner, single-outstanding imem fetch, decode output register
// Rev 1.0
// ============================================================================
module pc_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  pc_fetch_ctrl_if.master      bus,
  output logic [XLEN-1:0]      increment_pc,
  input  wire logic [XLEN-1:0] jump_pc,
  input  wire logic            branch,
  input  wire logic            zero_bit
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_drop;
  logic            w_drop_nxt;
  logic            w_capture;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            w_redirect;
  logic [XLEN-1:0] w_target;

  assign w_redirect   = branch & zero_bit;
  assign w_target     = jump_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign increment_pc = r_pc + XLEN'(PC_STEP);

  assign bus.imem_req    = (r_state == S_REQ);
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = (r_state == S_HOLD);
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (w_redirect) w_pc_nxt = w_target;
      end
      S_REQ: begin
        if (bus.imem_gnt) begin
          w_state_nxt = S_WAIT;
          // Granted in the redirect cycle: the word in flight belongs to the old path
          if (w_redirect) begin
            w_pc_nxt   = w_target;
            w_drop_nxt = 1'b1;
          end
        end else if (w_redirect) begin
          w_pc_nxt = w_target;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          w_drop_nxt = 1'b0;
          if (w_redirect) begin
            w_pc_nxt    = w_target;
            w_state_nxt = S_REQ;
          end else if (r_drop) begin
            w_state_nxt = S_REQ;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else if (w_redirect) begin
          w_pc_nxt   = w_target;
          w_drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_REQ;
        end else if (bus.instr_ready) begin
          w_pc_nxt    = increment_pc;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_drop  <= w_drop_nxt;
      if (w_capture) begin
        r_instr    <= bus.imem_rdata;
        r_instr_pc <= r_pc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch_ctrl : directed scenarios plus random traffic against a fetch model
// Rev 1.0
// ============================================================================
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] increment_pc;
  logic [31:0] jump_pc = '0;
  logic        branch = 1'b0;
  logic        zero_bit = 1'b0;

  int tests = 0;
  int fails = 0;

  pc_fetch_ctrl_if #(.XLEN(32)) bus ();

  pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .increment_pc (increment_pc),
    .jump_pc      (jump_pc),
    .branch       (branch),
    .zero_bit     (zero_bit)
  );

  always #5 clk = ~clk;

  // Reference: a fetch is either just out of reset, presenting a word,
  // waiting on an accepted request (possibly poisoned), or asking for pc.
  logic [31:0] m_pc;
  logic        m_fresh;
  logic        m_inflight;
  logic        m_poison;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_redir;
  logic [31:0] m_tgt;

  assign m_redir = branch & zero_bit;
  assign m_tgt   = jump_pc & 32'hFFFF_FFFC;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc       <= 32'h0;
      m_fresh    <= 1'b1;
      m_inflight <= 1'b0;
      m_poison   <= 1'b0;
      m_valid    <= 1'b0;
      m_instr    <= 32'h0;
      m_ipc      <= 32'h0;
    end else if (m_fresh) begin
      m_fresh <= 1'b0;
      if (m_redir) m_pc <= m_tgt;
    end else if (m_valid) begin
      if (m_redir) begin
        m_valid <= 1'b0;
        m_pc    <= m_tgt;
      end else if (bus.instr_ready) begin
        m_valid <= 1'b0;
        m_pc    <= m_pc + 32'd4;
      end
    end else if (m_inflight) begin
      if (bus.imem_rvalid) begin
        m_inflight <= 1'b0;
        if (m_redir || m_poison) begin
          m_poison <= 1'b0;
          if (m_redir) m_pc <= m_tgt;
        end else begin
          m_valid <= 1'b1;
          m_instr <= bus.imem_rdata;
          m_ipc   <= m_pc;
        end
      end else if (m_redir) begin
        m_poison <= 1'b1;
        m_pc     <= m_tgt;
      end
    end else begin
      if (bus.imem_gnt) begin
        m_inflight <= 1'b1;
        if (m_redir) begin
          m_poison <= 1'b1;
          m_pc     <= m_tgt;
        end
      end else if (m_redir) begin
        m_pc <= m_tgt;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_req",   {31'b0, bus.imem_req}, {31'b0, !m_fresh && !m_inflight && !m_valid});
    chk("m_addr",  bus.imem_addr, m_pc);
    chk("m_inc",   increment_pc, m_pc + 32'd4);
    chk("m_valid", {31'b0, bus.instr_valid}, {31'b0, m_valid});
    chk("m_instr", bus.instr, m_instr);
    chk("m_ipc",   bus.instr_pc, m_ipc);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] data);
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    cyc();
    bus.imem_rvalid = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    branch   = 1'b1;
    zero_bit = 1'b1;
    jump_pc  = target;
    cyc();
    branch   = 1'b0;
    zero_bit = 1'b0;
  endtask

  initial begin
    int n;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;

    #7;
    chk("rst_req",   {31'b0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_inc",   increment_pc, 32'h4);
    #5 rst_n = 1'b1;

    // 1: first fetch
    bus.instr_ready = 1'b1;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      cyc();
      n++;
    end
    chk("t1_req_seen", {31'b0, bus.imem_req}, 32'd1);
    chk("t1_addr", bus.imem_addr, 32'h0);
    fetch(32'h0050_0093);
    chk("t1_valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("t1_instr", bus.instr, 32'h0050_0093);
    chk("t1_ipc",   bus.instr_pc, 32'h0);
    cyc();
    chk("t1_next_addr", bus.imem_addr, 32'h4);

    // 2: decode stall
    bus.instr_ready = 1'b0;
    fetch(32'h1111_1111);
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", {31'b0, bus.instr_valid}, 32'd1);
      chk("t2_ipc",   bus.instr_pc, 32'h4);
      chk("t2_noreq", {31'b0, bus.imem_req}, 32'd0);
      cyc();
    end
    bus.instr_ready = 1'b1;
    cyc();
    bus.instr_ready = 1'b0;
    chk("t2_addr", bus.imem_addr, 32'h8);

    // 3: redirect from HOLD, misaligned target
    fetch(32'h2222_2222);
    chk("t3_ipc", bus.instr_pc, 32'h8);
    redirect(32'h25);
    chk("t3_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("t3_addr",  bus.imem_addr, 32'h24);

    // 4: redirect during WAIT, late response dropped
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0;
    redirect(32'h40);
    cyc();
    cyc();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    cyc();
    bus.imem_rvalid = 1'b0;
    chk("t4_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("t4_instr", bus.instr, 32'h2222_2222);
    chk("t4_addr",  bus.imem_addr, 32'h40);

    // 5: half-asserted redirect conditions are inert
    redirect(32'h10);
    chk("t5_addr", bus.imem_addr, 32'h10);
    zero_bit = 1'b1;
    fetch(32'h3333_3333);
    chk("t5_ipc", bus.instr_pc, 32'h10);
    branch = 1'b1;
    zero_bit = 1'b0;
    bus.instr_ready = 1'b1;
    cyc();
    branch = 1'b0;
    bus.instr_ready = 1'b0;
    chk("t5_next", bus.imem_addr, 32'h14);

    // 6: wrap and mid-WAIT reset with stray response
    redirect(32'hFFFF_FFFF);
    chk("t6_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("t6_inc",  increment_pc, 32'h0);
    fetch(32'h4444_4444);
    bus.instr_ready = 1'b1;
    cyc();
    bus.instr_ready = 1'b0;
    chk("t6_wrap", bus.imem_addr, 32'h0);
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0;
    rst_n = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h5555_5555;
    #1;
    chk("t6_rst_req",   {31'b0, bus.imem_req}, 32'd0);
    chk("t6_rst_instr", bus.instr, 32'h0);
    chk("t6_rst_ipc",   bus.instr_pc, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t6_restart", {31'b0, bus.imem_req}, 32'd1);
    cyc();
    chk("t6_stray_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("t6_stray_addr",  bus.imem_addr, 32'h0);
    bus.imem_rvalid = 1'b0;

    // Random traffic, including occasional asynchronous reset
    for (int i = 0; i < 4000; i++) begin
      bus.imem_gnt    = ($urandom_range(0, 1) == 1);
      bus.imem_rvalid = ($urandom_range(0, 9) < 4);
      bus.imem_rdata  = $urandom;
      bus.instr_ready = ($urandom_range(0, 9) < 6);
      branch          = ($urandom_range(0, 9) < 2);
      zero_bit        = ($urandom_range(0, 1) == 1);
      jump_pc         = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
    end

    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    branch          = 1'b0;
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
